// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//
// Purpose:
//    Shared definitions for the instruction-memory byte-stream loader.
//    Holds the loader FSM state enum, the default frame start marker, the
//    frame field constants and a small length-check helper.
//
// Contents:
//    state_t            loader FSM states (IDLE, LEN_LO, LEN_HI, DATA, CSUM)
//    SYNC_BYTE_DEFAULT  default frame start marker
//    HDR_LEN            bytes in the frame header (sync + 16-bit length)
//    CSUM_W             checksum width in bits
//    LEN_W              width of the word-count length field
//    len_fits()         does a word count fit in a memory of a given byte depth
// ---------------------------------------------------------------------------
package imem_loader_pkg;

   // Loader FSM states, in the order a frame walks through them.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM
   } state_t;

   // Marker that opens a frame when seen in IDLE.
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Sync byte plus the two length bytes.
   localparam int HDR_LEN = 3;

   // The trailing checksum is a plain 8-bit modular sum of the payload.
   localparam int CSUM_W = 8;

   // Length field is a 16-bit count of 32-bit words.
   localparam int LEN_W = 16;

   // True when 'len' words fit into a memory of 'depth_bytes' bytes.
   // Comparing words against depth/4 keeps the arithmetic in 32 bits with
   // no risk of the len*4 product overflowing.
   function automatic logic len_fits(input logic [LEN_W-1:0] len,
                                     input int unsigned depth_bytes);
      logic [31:0] len_ext;
      len_ext = {{(32-LEN_W){1'b0}}, len};
      return (len_ext <= (depth_bytes / 32'd4));
   endfunction

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//    Programs the instruction memory from a framed byte stream delivered by
//    a host link (UART or debug bridge). A frame is
//       SYNC, LEN_LO, LEN_HI, 4*LEN payload bytes, CSUM
//    where LEN counts 32-bit words and CSUM is the mod-256 sum of the payload.
//    Payload bytes are assembled little-endian into words and written to
//    consecutive word addresses starting at 0. The core is held in reset
//    (cpu_hold) from the sync byte until the frame ends, and the frame result
//    is reported on load_done / load_err.
//
// Parameters:
//    NUM_INST   instruction memory depth in bytes (multiple of 4)
//    ADDR_W     width of the memory byte address
//    SYNC_BYTE  frame start marker
//
// Ports:
//    clk        in   single clock
//    rst_n      in   asynchronous active-low reset
//    in_data    in   stream byte
//    in_valid   in   in_data is valid
//    in_ready   out  byte accepted when in_valid && in_ready (1 out of reset)
//    mem_we     out  one-cycle write strobe to the instruction memory
//    mem_addr   out  word-aligned byte address of the write
//    mem_wdata  out  word written, byte 0 in [7:0]
//    cpu_hold   out  keep the core / PC in reset while high
//    load_done  out  last frame completed with a good checksum
//    load_err   out  last frame failed its length or checksum check
// ---------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         NUM_INST  = 64,
   parameter int         ADDR_W    = 32,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   state_t              state;
   logic [LEN_W-1:0]    len_words;
   logic [LEN_W-1:0]    word_cnt;
   logic [1:0]          byte_idx;
   logic [23:0]         word_buf;
   logic [CSUM_W-1:0]   csum;
   logic [ADDR_W-1:0]   next_addr;

   logic                accept;
   logic [LEN_W-1:0]    len_full;
   logic                len_too_big;
   logic                last_word;

   // A byte is consumed whenever the host offers one; in_ready is only low
   // while reset is asserted, so there is never any backpressure.
   assign accept = in_valid && in_ready;

   // While in LEN_HI the full length is the incoming high byte joined with
   // the low byte captured one accepted byte earlier. The length check has to
   // look at this combined value, since len_words is not updated until the
   // clock edge that leaves LEN_HI.
   assign len_full    = {in_data, len_words[7:0]};
   assign len_too_big = !len_fits(len_full, $unsigned(NUM_INST));

   // The word now being completed is the last one of the frame when the
   // count of words already written is one short of the length.
   assign last_word = (LEN_W'(word_cnt + LEN_W'(1)) == len_words);

   // Single FSM plus datapath. Every output is a register here so the memory
   // and the core see clean, glitch-free controls. mem_we defaults low each
   // cycle so it can only ever be a one-cycle pulse. mem_addr and mem_wdata
   // are only loaded on a write and otherwise keep the last written
   // address/word. A sync byte is only recognised in IDLE; anywhere else it
   // is ordinary length, payload or checksum data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         len_words <= '0;
         word_cnt  <= '0;
         byte_idx  <= '0;
         word_buf  <= '0;
         csum      <= '0;
         next_addr <= '0;
      end else begin
         in_ready <= 1'b1;
         mem_we   <= 1'b0;

         if (accept) begin
            case (state)
               ST_IDLE: begin
                  // Non-sync bytes are line noise and are dropped. A sync
                  // opens a new frame: grab the core, clear the previous
                  // result and restart addressing and checksum from zero.
                  if (in_data == SYNC_BYTE) begin
                     state     <= ST_LEN_LO;
                     cpu_hold  <= 1'b1;
                     load_done <= 1'b0;
                     load_err  <= 1'b0;
                     next_addr <= '0;
                     word_cnt  <= '0;
                     byte_idx  <= '0;
                     csum      <= '0;
                  end
               end

               ST_LEN_LO: begin
                  len_words[7:0] <= in_data;
                  state          <= ST_LEN_HI;
               end

               ST_LEN_HI: begin
                  len_words[15:8] <= in_data;
                  if (len_too_big) begin
                     // A frame that cannot fit is refused before any
                     // payload is written, and the core is let go at once.
                     state    <= ST_IDLE;
                     load_err <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (len_full == '0) begin
                     state <= ST_CSUM;
                  end else begin
                     state <= ST_DATA;
                  end
               end

               ST_DATA: begin
                  csum     <= csum + in_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     // Fourth byte completes the word: it goes straight into
                     // the top lane of the write data alongside the three
                     // buffered lower bytes.
                     mem_we    <= 1'b1;
                     mem_addr  <= next_addr;
                     mem_wdata <= {in_data, word_buf};
                     next_addr <= next_addr + ADDR_W'(4);
                     word_cnt  <= word_cnt + LEN_W'(1);
                     if (last_word) begin
                        state <= ST_CSUM;
                     end
                  end else begin
                     case (byte_idx)
                        2'd0:    word_buf[7:0]   <= in_data;
                        2'd1:    word_buf[15:8]  <= in_data;
                        default: word_buf[23:16] <= in_data;
                     endcase
                  end
               end

               ST_CSUM: begin
                  // Writes already issued stay in memory either way; the
                  // host sees load_err and is expected to reload.
                  load_done <= (in_data == csum);
                  load_err  <= (in_data != csum);
                  cpu_hold  <= 1'b0;
                  state     <= ST_IDLE;
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Purpose:
//    Self-checking bench for imem_loader. Frames are built as byte queues,
//    and the expected writes and frame result are derived from the frame
//    contents (length field, payload words, payload sum) rather than from
//    the loader's internal state.
// ---------------------------------------------------------------------------
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int NUM_INST = 64;
   localparam int ADDR_W   = 32;

   logic              clk;
   logic              rst_n;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   int checks = 0;
   int errors = 0;

   // Bytes of the stimulus about to be sent and every write seen on the
   // memory port since the capture queues were last cleared.
   logic [7:0]  txBytes[$];
   logic [31:0] gotAddr[$];
   logic [31:0] gotData[$];

   imem_loader #(
      .NUM_INST (NUM_INST),
      .ADDR_W   (ADDR_W),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .load_done(load_done),
      .load_err (load_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge, logging any write.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (mem_we !== 1'b0) begin
         gotAddr.push_back(mem_addr);
         gotData.push_back(mem_wdata);
      end
   endtask

   // Sends txBytes one per accepted cycle with optional random idle gaps
   // (garbage on in_data while in_valid is low). cpu_hold must be high
   // after byte syncIdx up to, but not including, byte holdEnd.
   task automatic applyStimulus(input int syncIdx, input int holdEnd,
                                input int maxGap, input string tag);
      for (int i = 0; i < txBytes.size(); i++) begin
         in_data  = txBytes[i];
         in_valid = 1'b1;
         stepCycle();
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         checkOutput($sformatf("%s hold[%0d]", tag, i), 32'(cpu_hold),
                     32'(i >= syncIdx && i < holdEnd));
         if (i == syncIdx) begin
            checkOutput({tag, " done cleared"}, 32'(load_done), 32'd0);
            checkOutput({tag, " err cleared"}, 32'(load_err), 32'd0);
         end
         repeat ($urandom_range(maxGap, 0)) stepCycle();
      end
   endtask

   // Sends the complete frame in txBytes (sync at syncIdx) and checks the
   // writes and result the frame contents call for.
   task automatic runAndCheck(input int syncIdx, input int maxGap, input string tag);
      int          len;
      bit          fits;
      int          sum;
      logic [7:0]  csumByte;
      logic [31:0] expAddr[$];
      logic [31:0] expData[$];
      logic [31:0] word;

      len  = int'({txBytes[syncIdx+2], txBytes[syncIdx+1]});
      fits = (len * 4 <= NUM_INST);
      sum  = 0;
      if (fits) begin
         for (int w = 0; w < len; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
               word = word | (32'(txBytes[syncIdx + HDR_LEN + 4*w + b]) << (8*b));
               sum  = sum + int'(txBytes[syncIdx + HDR_LEN + 4*w + b]);
            end
            expAddr.push_back(32'(4 * w));
            expData.push_back(word);
         end
         csumByte = txBytes[syncIdx + HDR_LEN + 4*len];
      end else begin
         csumByte = 8'd0;
      end

      gotAddr.delete();
      gotData.delete();
      applyStimulus(syncIdx, txBytes.size() - 1, maxGap, tag);
      stepCycle();

      checkOutput({tag, " write count"}, 32'(gotAddr.size()), 32'(expAddr.size()));
      for (int k = 0; k < expAddr.size() && k < gotAddr.size(); k++) begin
         checkOutput($sformatf("%s addr[%0d]", tag, k), gotAddr[k], expAddr[k]);
         checkOutput($sformatf("%s data[%0d]", tag, k), gotData[k], expData[k]);
      end
      checkOutput({tag, " done"}, 32'(load_done), 32'(fits && (sum % 256) == int'(csumByte)));
      checkOutput({tag, " err"}, 32'(load_err), 32'(!fits || (sum % 256) != int'(csumByte)));
      checkOutput({tag, " hold end"}, 32'(cpu_hold), 32'd0);
      if (expAddr.size() > 0) begin
         checkOutput({tag, " addr held"}, mem_addr, expAddr[expAddr.size()-1]);
         checkOutput({tag, " data held"}, mem_wdata, expData[expData.size()-1]);
      end
   endtask

   // Builds noise + frame into txBytes. Oversized lengths produce only the
   // header, since the loader abandons the frame after LEN_HI.
   task automatic buildFrame(input int noise, input int len, input bit badCsum);
      logic [7:0] b;
      int         sum;
      txBytes.delete();
      for (int n = 0; n < noise; n++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         txBytes.push_back(b);
      end
      txBytes.push_back(8'hA5);
      txBytes.push_back(8'(len));
      txBytes.push_back(8'(len >> 8));
      if (len * 4 <= NUM_INST) begin
         sum = 0;
         for (int i = 0; i < 4 * len; i++) begin
            b = ($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom);
            sum = sum + int'(b);
            txBytes.push_back(b);
         end
         txBytes.push_back(8'(sum + (badCsum ? 1 : 0)));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset mem_addr", mem_addr, 32'd0);
      checkOutput("reset mem_wdata", mem_wdata, 32'd0);
      checkOutput("reset cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("reset load_done", 32'(load_done), 32'd0);
      checkOutput("reset load_err", 32'(load_err), 32'd0);
      rst_n = 1'b1;
      gotAddr.delete();
      repeat (4) stepCycle();
      checkOutput("idle in_ready", 32'(in_ready), 32'd1);
      checkOutput("idle cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("idle no writes", 32'(gotAddr.size()), 32'd0);

      // Noise then a good two-word frame.
      txBytes = '{8'h00, 8'h13, 8'hA5, 8'h02, 8'h00,
                  8'h33, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h40, 8'hA6};
      runAndCheck(2, 0, "frameA");
      checkOutput("frameA word0", gotData.size() > 0 ? gotData[0] : 32'hxxxxxxxx, 32'h0000_0033);
      checkOutput("frameA word1", gotData.size() > 1 ? gotData[1] : 32'hxxxxxxxx, 32'h4000_0033);
      checkOutput("frameA done", 32'(load_done), 32'd1);

      // Same frame with a wrong checksum: writes still happen, error flagged.
      txBytes = '{8'hA5, 8'h02, 8'h00,
                  8'h33, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h40, 8'hA7};
      runAndCheck(0, 1, "frameBad");
      checkOutput("frameBad err", 32'(load_err), 32'd1);
      checkOutput("frameBad done", 32'(load_done), 32'd0);

      // Oversized length (17 words > 64 bytes) is refused right after LEN_HI.
      txBytes = '{8'hA5, 8'h11, 8'h00};
      runAndCheck(0, 0, "tooLong");
      checkOutput("tooLong err", 32'(load_err), 32'd1);

      // Zero-length frame straight after: also proves the FSM is back in IDLE.
      txBytes = '{8'hA5, 8'h00, 8'h00, 8'h00};
      runAndCheck(0, 0, "zeroLen");
      checkOutput("zeroLen done", 32'(load_done), 32'd1);

      // Exactly full memory (16 words) is accepted.
      buildFrame(0, NUM_INST / 4, 1'b0);
      runAndCheck(0, 0, "fullMem");

      // Reset after 6 payload bytes: one write only, everything back to reset.
      txBytes = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      gotAddr.delete();
      gotData.delete();
      applyStimulus(0, txBytes.size(), 0, "midReset");
      stepCycle();
      checkOutput("midReset writes", 32'(gotAddr.size()), 32'd1);
      checkOutput("midReset word0", gotData.size() > 0 ? gotData[0] : 32'hxxxxxxxx, 32'h4433_2211);
      rst_n = 1'b0;
      #1;
      checkOutput("midReset hold", 32'(cpu_hold), 32'd0);
      checkOutput("midReset in_ready", 32'(in_ready), 32'd0);
      checkOutput("midReset mem_addr", mem_addr, 32'd0);
      checkOutput("midReset mem_wdata", mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stepCycle();
      buildFrame(2, 3, 1'b0);
      runAndCheck(2, 2, "afterReset");
      checkOutput("afterReset done", 32'(load_done), 32'd1);

      // Randomised frames: lengths around the limit, occasional bad checksum,
      // random noise and idle gaps.
      for (int it = 0; it < 12; it++) begin
         int len;
         int noise;
         len   = (it == 3) ? 17 : (it == 7) ? 300 : $urandom_range(16, 0);
         noise = $urandom_range(3, 0);
         buildFrame(noise, len, $urandom_range(3, 0) == 0);
         runAndCheck(noise, (it % 2) * 3, $sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the instruction memory: the write-side counterpart to the combinational fetch port the core reads from. It accepts a framed byte stream from a host link (UART or debug bridge), assembles little-endian 32-bit instruction words, writes them to the instruction memory's write port at consecutive word addresses, and holds the core in reset while loading. Framing, length check and checksum let the host detect a corrupted download before the core is released.

## Interface

Parameters:
- NUM_INST, 64: instruction memory depth in bytes, matching the fetch-side memory. Must be a multiple of 4.
- ADDR_W, 32: width of the memory byte address.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  ADDR_W  byte address, word-aligned (bits [1:0] = 0).
- mem_wdata  output  32  word written; byte 0 in [7:0].
- cpu_hold  output  1  hold core/PC in reset while high.
- load_done  output  1  last frame completed with a good checksum.
- load_err  output  1  last frame failed on length or checksum.

## Operation

- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*LEN payload bytes (little-endian words), then CSUM. LEN is a 16-bit word count. CSUM is the 8-bit sum mod 256 of the payload bytes only.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM.
  - IDLE: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to LEN_LO and sets cpu_hold=1, clears load_done and load_err, and zeroes the address, byte counter and checksum.
  - LEN_LO, then LEN_HI: capture LEN.
  - From LEN_HI: if LEN*4 > NUM_INST, go to IDLE with load_err=1 and cpu_hold=0. If LEN==0, go to CSUM. Otherwise go to DATA.
  - DATA: a 2-bit byte index fills the word from byte 0 to byte 3, and each byte is added to the checksum. On the 4th byte, issue a write. After LEN words, go to CSUM.
  - CSUM: on a match, set load_done=1. On a mismatch, set load_err=1. In both cases clear cpu_hold and return to IDLE.
- Writes are not rolled back on a checksum error. The host must reload.
- in_ready is 1 in every state. There is no backpressure; the loader consumes one byte per cycle.
- A SYNC_BYTE value inside LEN, DATA or CSUM is treated as data, not as a restart.
- Address increments by 4 after each write and never exceeds NUM_INST-4, which is guaranteed by the length check.

## Timing

- Reset values: in_ready=0 during reset and 1 after; mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0; FSM=IDLE.
- All outputs are registered.
- mem_we pulses exactly one cycle, on the cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are valid in that same cycle and hold until the next write.
- cpu_hold rises on the cycle after SYNC_BYTE is accepted.
- cpu_hold falls on the cycle after the CSUM byte is accepted. load_done or load_err rises in that same cycle.
- Back-to-back bytes with no gaps are supported. Idle cycles (in_valid=0) anywhere in a frame are tolerated with no timeout.
- Reset mid-frame: everything returns to reset values immediately, cpu_hold drops, and partially written memory is left as is.

## Structure

- Shared package: FSM state enum, SYNC_BYTE default, and the frame field constants (header length 3, checksum width 8).
- No sub-module. A single FSM plus datapath registers (word shift register, byte index, word counter, checksum) is sufficient.

## Test plan

- Reset, then in_valid low: all outputs at reset values, in_ready=1, no mem_we.
- Noise bytes 0x00, 0x13 in IDLE, then frame A5 02 00 | 33 00 00 00 | 33 00 00 40 | CSUM=0xA6:
  - writes 0x00000033 at address 0 and 0x40000033 at address 4;
  - load_done=1, cpu_hold high from the cycle after A5 until the cycle after CSUM.
- Same frame with CSUM=0xA7: both writes still occur, load_err=1, load_done=0, cpu_hold=0.
- NUM_INST=64 with frame A5 11 00: no mem_we, load_err=1 right after LEN_HI, FSM back to IDLE.
- Zero-length frame A5 00 00 00: no writes, load_done=1.
- Assert rst_n low after 6 payload bytes, then a full valid frame: the first frame produces only one write, and the second frame completes with load_done=1.
